// File: rtl/disc_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : disc_sched_pkg
// Description : Shared types and constants for the discriminator MAC
//               scheduler: scheduler FSM state encoding, frame geometry and
//               the nominal engine latency.
// Revision    : 1.0 - initial release
// ============================================================================
package disc_sched_pkg;

    localparam int FRAME_W    = 4096;   // one flattened frame
    localparam int ELEM_W     = 16;     // Q8.8 element
    localparam int N_ELEM     = 256;    // elements per frame
    localparam int SCORE_W    = 16;     // Q8.8 logit
    localparam int ENGINE_LAT = 257;    // start-to-done cycles of the engine

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESULT = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. The search starts at the
//               requester just after last_grant and wraps around.
// Ports       : req        - per-requester request vector
//               last_grant - index of the previous winner
//               grant      - one-hot winner (zero when no request)
//               grant_id   - binary index of the winner
//               any        - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 2,
    localparam int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last_grant,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id,
    output logic            any
);

    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        // Offsets 1..N visit every requester once, ending on last_grant
        // itself so a lone repeat requester still wins.
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (int'(last_grant) + k) % N;
            if (!any && req[idx]) begin
                any       = 1'b1;
                grant[idx] = 1'b1;
                grant_id  = ID_W'(idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/disc_mac_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : disc_mac_scheduler
// Description : Time-shares one layer1_discriminator MAC engine between
//               N_REQ frame sources. A round-robin winner's frame is latched
//               into a holding register, the engine is started, and its
//               score/decision is returned tagged with the requester ID.
//               A watchdog aborts (and resets) a hung engine.
// Ports       : clk, rst                    - clock, sync active-high reset
//               req_valid/req_ready/req_data - per-requester frame intake
//               disc_input/start/rst         - engine drive
//               disc_score/real/done         - engine results
//               res_valid/ready/id/score/real/timeout - result handshake
//               busy, frames_done            - status
// Revision    : 1.0 - initial release
// ============================================================================
module disc_mac_scheduler
    import disc_sched_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 512,
    localparam int ID_W   = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*FRAME_W-1:0] req_data,
    output logic [FRAME_W-1:0]       disc_input,
    output logic                     disc_start,
    output logic                     disc_rst,
    input  logic [SCORE_W-1:0]       disc_score,
    input  logic                     disc_real,
    input  logic                     disc_done,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [ID_W-1:0]          res_id,
    output logic [SCORE_W-1:0]       res_score,
    output logic                     res_real,
    output logic                     res_timeout,
    output logic                     busy,
    output logic [15:0]              frames_done
);

    localparam int WD_W = $clog2(TIMEOUT) + 1;

    state_t            r_state;
    state_t            w_state_next;
    logic [ID_W-1:0]   r_last_grant;
    logic [WD_W-1:0]   r_wd;
    logic              r_abort;

    logic [N_REQ-1:0]  w_grant;
    logic [ID_W-1:0]   w_grant_id;
    logic              w_any;
    logic              w_take;
    logic              w_capture;
    logic              w_abort;
    logic              w_handshake;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req        (req_valid),
        .last_grant (r_last_grant),
        .grant      (w_grant),
        .grant_id   (w_grant_id),
        .any        (w_any)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_take       = 1'b0;
        w_capture    = 1'b0;
        w_abort      = 1'b0;
        w_handshake  = 1'b0;
        req_ready    = '0;
        disc_start   = 1'b0;
        res_valid    = 1'b0;
        busy         = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                // Gated by rst so nothing is accepted while reset is applied.
                if (w_any && !rst) begin
                    req_ready    = w_grant;
                    w_take       = 1'b1;
                    w_state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                disc_start   = !rst;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                // A done on the final watchdog cycle still counts as success.
                if (disc_done) begin
                    w_capture    = 1'b1;
                    w_state_next = S_RESULT;
                end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
                    w_abort      = 1'b1;
                    w_state_next = S_RESULT;
                end
            end
            S_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_handshake  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= ID_W'(N_REQ - 1);
            r_wd         <= '0;
            r_abort      <= 1'b0;
            disc_input   <= '0;
            res_id       <= '0;
            res_score    <= '0;
            res_real     <= 1'b0;
            res_timeout  <= 1'b0;
            frames_done  <= '0;
        end else begin
            r_abort <= 1'b0;
            if (w_take) begin
                disc_input   <= req_data[int'(w_grant_id) * FRAME_W +: FRAME_W];
                res_id       <= w_grant_id;
                r_last_grant <= w_grant_id;
            end
            if (r_state == S_LAUNCH)    r_wd <= '0;
            else if (r_state == S_WAIT) r_wd <= r_wd + WD_W'(1);
            if (w_capture) begin
                res_score   <= disc_score;
                res_real    <= disc_real;
                res_timeout <= 1'b0;
            end
            if (w_abort) begin
                res_score   <= '0;
                res_real    <= 1'b0;
                res_timeout <= 1'b1;
                r_abort     <= 1'b1;
            end
            if (w_handshake) frames_done <= frames_done + 16'd1;
        end
    end

    // The abort pulse is registered so it lines up with the first RESULT
    // cycle; the engine is also held in reset whenever the block is.
    assign disc_rst = rst | r_abort;

endmodule
`default_nettype wire

// File: tb/tb_disc_mac_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_disc_mac_scheduler
// Description : Self-checking bench for disc_mac_scheduler with a
//               behavioural MAC engine model (done 257 cycles after start).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_disc_mac_scheduler;

    localparam int N_REQ   = 2;
    localparam int TIMEOUT = 512;
    localparam int FW      = 4096;

    logic                  clk;
    logic                  rst;
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ*FW-1:0]   req_data;
    logic [FW-1:0]         disc_input;
    logic                  disc_start;
    logic                  disc_rst;
    logic [15:0]           disc_score;
    logic                  disc_real;
    logic                  disc_done;
    logic                  res_valid;
    logic                  res_ready;
    logic [0:0]            res_id;
    logic [15:0]           res_score;
    logic                  res_real;
    logic                  res_timeout;
    logic                  busy;
    logic [15:0]           frames_done;

    disc_mac_scheduler #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .disc_input  (disc_input),
        .disc_start  (disc_start),
        .disc_rst    (disc_rst),
        .disc_score  (disc_score),
        .disc_real   (disc_real),
        .disc_done   (disc_done),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_id      (res_id),
        .res_score   (res_score),
        .res_real    (res_real),
        .res_timeout (res_timeout),
        .busy        (busy),
        .frames_done (frames_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural engine: done is high 257 cycles after the start cycle.
    logic        eng_en;
    logic        forced_done;
    logic        e_run;
    int          e_cnt;
    logic [15:0] eng_score;
    logic        eng_real;

    always @(posedge clk) begin
        if (disc_rst) begin
            e_run <= 1'b0;
            e_cnt <= 0;
        end else if (disc_start) begin
            e_run <= 1'b1;
            e_cnt <= 1;
        end else if (e_run) begin
            e_cnt <= e_cnt + 1;
            if (e_cnt == 257) e_run <= 1'b0;
        end
    end
    assign disc_done  = (e_run && e_cnt == 257 && eng_en) || forced_done;
    assign disc_score = eng_score;
    assign disc_real  = eng_real;

    // Pulse monitors, sampled on the rising edge (pre-edge values).
    int rr_pulses = 0;
    int ab_pulses = 0;
    always @(posedge clk) begin
        if (req_ready != '0)  rr_pulses <= rr_pulses + 1;
        if (disc_rst && !rst) ab_pulses <= ab_pulses + 1;
    end

    logic [FW-1:0] frame0;
    logic [FW-1:0] frame1;

    int checks = 0;
    int errors = 0;
    int exp_frames = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  valid;
        logic [15:0] score;
        logic        rl;
        bit          hang;
        int          bp;
        int          done_at;
        logic [0:0]  exp_id;
        logic        exp_to;
        logic [15:0] exp_score;
        logic        exp_real;
        int          exp_lat;
    } vec_t;

    task automatic run_txn(input vec_t v);
        int   t0;
        bit   found;
        bit   got;
        bit   stable;
        bit   bp_ok;
        int   rr0;
        int   ab0;
        logic [FW-1:0] exp_frame;
        exp_frame = v.exp_id ? frame1 : frame0;
        req_valid = v.valid;
        eng_en    = !v.hang;
        eng_score = v.score;
        eng_real  = v.rl;
        res_ready = 1'b0;
        rr0 = rr_pulses;
        ab0 = ab_pulses;
        #1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready != '0) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("accept_seen", 32'(found), 1);
        t0 = cyc;
        check("grant_onehot", 32'(req_ready), 32'(2'b01 << v.exp_id));

        got = 0;
        stable = 1;
        for (int i = 0; i < TIMEOUT + 20; i++) begin
            @(negedge clk);
            forced_done = (v.done_at > 0 && cyc == t0 + v.done_at);
            if (res_valid) begin
                got = 1;
                break;
            end
            if (disc_input !== exp_frame || !busy || req_ready != '0) stable = 0;
        end
        forced_done = 1'b0;
        check("result_seen", 32'(got), 1);
        check("input_stable_busy", 32'(stable), 1);
        check("latency", 32'(cyc - t0), 32'(v.exp_lat));
        check("res_id", 32'(res_id), 32'(v.exp_id));
        check("res_score", 32'(res_score), 32'(v.exp_score));
        check("res_real", 32'(res_real), 32'(v.exp_real));
        check("res_timeout", 32'(res_timeout), 32'(v.exp_to));
        check("abort_in_first_result", 32'(disc_rst), 32'(v.exp_to));

        if (v.bp > 0) begin
            bp_ok = 1;
            for (int i = 0; i < v.bp; i++) begin
                @(negedge clk);
                if (!res_valid || res_id !== v.exp_id || res_score !== v.exp_score ||
                    res_real !== v.exp_real || res_timeout !== v.exp_to ||
                    req_ready != '0 || !busy || disc_rst)
                    bp_ok = 0;
            end
            check("backpressure_hold", 32'(bp_ok), 1);
        end

        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        exp_frames++;
        check("frames_done", 32'(frames_done), 32'(exp_frames));
        check("res_valid_drop", 32'(res_valid), 0);
        check("ready_pulse_count", 32'(rr_pulses - rr0), 1);
        check("abort_pulse_count", 32'(ab_pulses - ab0), 32'(v.exp_to));
    endtask

    vec_t vecs[7];
    vec_t v;
    int   t0r;
    bit   found_r;

    initial begin
        frame0 = {256{16'h0100}};
        frame1 = {256{16'h0200}};
        req_data    = {frame1, frame0};
        req_valid   = '0;
        res_ready   = 1'b0;
        eng_en      = 1'b1;
        forced_done = 1'b0;
        eng_score   = '0;
        eng_real    = 1'b0;

        //         valid  score     rl  hang bp  done_at id  to  exp_score exp_real lat
        vecs[0] = '{2'b01, 16'h0234, 1, 0,   0,  0,      0,  0,  16'h0234, 1,  259};
        vecs[1] = '{2'b11, 16'h1111, 0, 0,   0,  0,      1,  0,  16'h1111, 0,  259};
        vecs[2] = '{2'b11, 16'h8000, 0, 0,   50, 0,      0,  0,  16'h8000, 0,  259};
        vecs[3] = '{2'b11, 16'h7fff, 1, 0,   0,  0,      1,  0,  16'h7fff, 1,  259};
        vecs[4] = '{2'b11, 16'h0001, 0, 0,   0,  0,      0,  0,  16'h0001, 0,  259};
        vecs[5] = '{2'b10, 16'hdead, 1, 1,   0,  0,      1,  1,  16'h0000, 0,  TIMEOUT + 2};
        vecs[6] = '{2'b01, 16'h0abc, 1, 0,   0,  0,      0,  0,  16'h0abc, 1,  259};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_res_fields", 32'({res_id, res_score, res_real, res_timeout}), 0);
        check("rst_frames_done", 32'(frames_done), 0);
        check("rst_disc_input", 32'(|disc_input), 0);
        check("rst_start_ready_busy", 32'({disc_start, req_ready, busy}), 0);
        check("rst_disc_rst", 32'(disc_rst), 1);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_disc_rst", 32'(disc_rst), 0);

        for (int i = 0; i < 7; i++) run_txn(vecs[i]);

        // Engine done lands on the very cycle the watchdog would fire.
        v = '{2'b01, 16'h0555, 1, 1, 0, TIMEOUT + 1, 0, 0, 16'h0555, 1, TIMEOUT + 2};
        run_txn(v);

        // Reset while the engine is running: no result, requester 0 first.
        req_valid = 2'b01;
        eng_en    = 1'b1;
        #1;
        found_r = 0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready != '0) begin
                found_r = 1;
                break;
            end
            @(negedge clk);
        end
        check("rstwait_accept", 32'({found_r, req_ready}), 32'({1'b1, 2'b01}));
        t0r = cyc;
        while (cyc < t0r + 100) @(negedge clk);
        rst = 1'b1;
        req_valid = 2'b11;
        @(negedge clk);
        check("midrst_outputs", 32'({res_valid, res_id, res_score, res_real, res_timeout,
                                     disc_start, req_ready, busy}), 0);
        check("midrst_frames_input", 32'({|frames_done, |disc_input}), 0);
        check("midrst_disc_rst", 32'(disc_rst), 1);
        rst = 1'b0;
        exp_frames = 0;
        v = '{2'b11, 16'h0321, 0, 0, 0, 0, 0, 0, 16'h0321, 0, 259};
        run_txn(v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
